// File: rtl/ysyx_22041071_mem_arbiter.sv
// Arbitrates the single 64-bit RAMHelper port between IF (read-only) and MEM (read/write), one transaction in flight.
// Define YSYX_22041071_ARB_RR_EN for round-robin arbitration instead of MEM priority with starvation counter.
module ysyx_22041071_mem_arbiter #(
   parameter logic [63:0] START_ADDR = 64'h8000_0000,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [63:0] if_addr,
   input  logic        if_flush,
   output logic        if_resp_valid,
   output logic [31:0] if_rdata,
   input  logic        mem_req_valid,
   output logic        mem_req_ready,
   input  logic [63:0] mem_addr,
   input  logic        mem_wen,
   input  logic [63:0] mem_wdata,
   input  logic [63:0] mem_wmask,
   output logic        mem_resp_valid,
   output logic [63:0] mem_rdata,
   output logic        ram_en,
   output logic [63:0] ram_ridx,
   output logic [63:0] ram_widx,
   output logic        ram_wen,
   output logic [63:0] ram_wdata,
   output logic [63:0] ram_wmask,
   input  logic [63:0] ram_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state_q;
   logic        owner_if_q;
   logic        wen_q;
   logic        sel_hi_q;
   logic        flushed_q;
   logic        ram_en_q;
   logic [63:0] ram_idx_q;
   logic        ram_wen_q;
   logic [63:0] ram_wdata_q;
   logic [63:0] ram_wmask_q;
   logic        if_resp_valid_q;
   logic [31:0] if_rdata_q;
   logic        mem_resp_valid_q;
   logic [63:0] mem_rdata_q;
`ifdef YSYX_22041071_ARB_RR_EN
   logic        last_if_q;
`else
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
   logic [3:0]  wait_cnt_q;
`endif

   logic        if_ok;
   logic        grant_if;
   logic        grant_mem;
   logic [63:0] req_addr;
   logic [63:0] idx_d;

   always_comb begin
      if_ok = if_req_valid && !if_flush;
`ifdef YSYX_22041071_ARB_RR_EN
      grant_if = if_ok && (!mem_req_valid || !last_if_q);
`else
      grant_if = if_ok && !(mem_req_valid && (wait_cnt_q < MAX_W));
`endif
      grant_mem = mem_req_valid && !grant_if;
      // readies must also read 0 while reset is held, since they are combinational
      if (state_q != IDLE || !reset) begin
         grant_if  = 1'b0;
         grant_mem = 1'b0;
      end
      req_addr = grant_if ? if_addr : mem_addr;
      idx_d    = (req_addr - START_ADDR) >> 3;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         owner_if_q       <= 1'b0;
         wen_q            <= 1'b0;
         sel_hi_q         <= 1'b0;
         flushed_q        <= 1'b0;
         ram_en_q         <= 1'b0;
         ram_idx_q        <= '0;
         ram_wen_q        <= 1'b0;
         ram_wdata_q      <= '0;
         ram_wmask_q      <= '0;
         if_resp_valid_q  <= 1'b0;
         if_rdata_q       <= '0;
         mem_resp_valid_q <= 1'b0;
         mem_rdata_q      <= '0;
`ifdef YSYX_22041071_ARB_RR_EN
         last_if_q        <= 1'b0;
`else
         wait_cnt_q       <= '0;
`endif
      end else begin
         if_resp_valid_q  <= 1'b0;
         mem_resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
`ifndef YSYX_22041071_ARB_RR_EN
               if (grant_if)
                  wait_cnt_q <= '0;
               else if (if_ok && wait_cnt_q < MAX_W)
                  wait_cnt_q <= wait_cnt_q + 4'd1;
`endif
               if (grant_if || grant_mem) begin
                  state_q     <= ISSUE;
                  owner_if_q  <= grant_if;
                  wen_q       <= grant_mem && mem_wen;
                  sel_hi_q    <= if_addr[2];
                  flushed_q   <= 1'b0;
                  ram_en_q    <= 1'b1;
                  ram_idx_q   <= idx_d;
                  ram_wen_q   <= grant_mem && mem_wen;
                  ram_wdata_q <= grant_mem ? mem_wdata : '0;
                  ram_wmask_q <= grant_mem ? mem_wmask : '0;
`ifdef YSYX_22041071_ARB_RR_EN
                  last_if_q   <= grant_if;
`endif
               end
            end
            ISSUE: begin
               state_q     <= RESP;
               flushed_q   <= owner_if_q && if_flush;
               ram_en_q    <= 1'b0;
               ram_idx_q   <= '0;
               ram_wen_q   <= 1'b0;
               ram_wdata_q <= '0;
               ram_wmask_q <= '0;
            end
            RESP: begin
               state_q <= IDLE;
               if (owner_if_q) begin
                  // a flush seen in ISSUE or RESP drops the fetch; old if_rdata is kept
                  if (!(flushed_q || if_flush)) begin
                     if_resp_valid_q <= 1'b1;
                     if_rdata_q      <= sel_hi_q ? ram_rdata[63:32] : ram_rdata[31:0];
                  end
               end else begin
                  mem_resp_valid_q <= 1'b1;
                  mem_rdata_q      <= wen_q ? '0 : ram_rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_req_ready   = grant_if;
   assign mem_req_ready  = grant_mem;
   assign if_resp_valid  = if_resp_valid_q;
   assign if_rdata       = if_rdata_q;
   assign mem_resp_valid = mem_resp_valid_q;
   assign mem_rdata      = mem_rdata_q;
   assign ram_en         = ram_en_q;
   assign ram_ridx       = ram_idx_q;
   assign ram_widx       = ram_idx_q;
   assign ram_wen        = ram_wen_q;
   assign ram_wdata      = ram_wdata_q;
   assign ram_wmask      = ram_wmask_q;

endmodule
